// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out bit source.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that indexes 0..width-1; a floor of 1 keeps the vector legal.
  function automatic int cnt_width(input int width);
    if (width > 2) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable WIDTH-bit shift register whose tap follows the configured bit order.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             shift,
  output logic             tap_next
);

  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] sreg_nxt_s;

  // Next register contents: load wins over shift, otherwise hold.
  always_comb begin
    sreg_nxt_s = sreg_r;
    if (load) begin
      sreg_nxt_s = din;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sreg_nxt_s = {sreg_r[WIDTH-2:0], 1'b0};
      end else begin
        sreg_nxt_s = {1'b0, sreg_r[WIDTH-1:1]};
      end
    end else begin
      sreg_nxt_s = sreg_r;
    end
  end

  // The tap of the next value lets the parent register x in the same edge.
  assign tap_next = MSB_FIRST ? sreg_nxt_s[WIDTH-1] : sreg_nxt_s[0];

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r <= '0;
    end else begin
      sreg_r <= sreg_nxt_s;
    end
  end

endmodule

// File: rtl/piso_bit_source.sv
// Serializes handshaked parallel words onto x, one bit per clock, with gapless reloads.
module piso_bit_source
  import piso_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             x_r;
  logic             x_valid_r;
  logic             last_r;
  logic             x_nxt_s;
  logic             x_valid_nxt_s;
  logic             last_nxt_s;
  logic             at_last_s;
  logic             load_s;
  logic             shift_s;
  logic             tap_nxt_s;

  assign at_last_s  = (state_r == SHIFT) && (cnt_r == CNT_MAX);
  assign load_ready = !rst && ((state_r == IDLE) || at_last_s);
  assign load_s     = load_valid && load_ready;
  assign shift_s    = (state_r == SHIFT) && !at_last_s;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .load     (load_s),
    .shift    (shift_s),
    .tap_next (tap_nxt_s)
  );

  // Next state, counter and output values; a load always restarts at bit 0.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    x_nxt_s       = IDLE_BIT;
    x_valid_nxt_s = 1'b0;
    last_nxt_s    = 1'b0;
    if (load_s) begin
      state_nxt_s   = SHIFT;
      cnt_nxt_s     = '0;
      x_nxt_s       = tap_nxt_s;
      x_valid_nxt_s = 1'b1;
      last_nxt_s    = 1'b0;
    end else if (shift_s) begin
      state_nxt_s   = SHIFT;
      cnt_nxt_s     = cnt_r + CNT_W'(1'b1);
      x_nxt_s       = tap_nxt_s;
      x_valid_nxt_s = 1'b1;
      last_nxt_s    = ((cnt_r + CNT_W'(1'b1)) == CNT_MAX);
    end else begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end
  end

  // FSM, counter and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      x_r       <= IDLE_BIT;
      x_valid_r <= 1'b0;
      last_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      x_r       <= x_nxt_s;
      x_valid_r <= x_valid_nxt_s;
      last_r    <= last_nxt_s;
    end
  end

  assign x       = x_r;
  assign x_valid = x_valid_r;
  assign last    = last_r;
  assign busy    = (state_r == SHIFT);

endmodule

// File: tb/tb_piso_bit_source.sv
// Scoreboard bench: an MSB-first and an LSB-first instance, expected bits queued at load time.
module tb_piso_bit_source;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din_m, din_l;
  logic         lv_m, lv_l;
  logic         rdy_m, rdy_l, x_m, x_l, xv_m, xv_l, last_m, last_l, busy_m, busy_l;

  always #5 clk = ~clk;

  piso_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .load_valid(lv_m), .load_ready(rdy_m),
    .x(x_m), .x_valid(xv_m), .last(last_m), .busy(busy_m)
  );

  piso_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(rdy_l),
    .x(x_l), .x_valid(xv_l), .last(last_l), .busy(busy_l)
  );

  typedef struct packed {
    logic x;
    logic last;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_word(input logic [W-1:0] w, input bit msb);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e.x    = msb ? w[W-1-k] : w[k];
      e.last = (k == W - 1);
      sb_q.push_back(e);
    end
  endtask

  // Expected {x, x_valid, last, busy}: next queued bit, or idle when the queue is empty.
  function automatic logic [3:0] next_exp();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      return {e.x, 1'b1, e.last, 1'b1};
    end
    return 4'b0000;
  endfunction

  task automatic test_reset();
    lv_m = 1'b0; lv_l = 1'b0; din_m = '0; din_l = '0;
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold got=%b exp=00000", {x_m, xv_m, last_m, busy_m, rdy_m});
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m, rdy_m, x_l, xv_l, last_l, busy_l, rdy_l} !== 10'b0000100001) begin
        n_err++;
        $display("FAIL reset_idle[%0d] got=%b exp=0000100001", i,
                 {x_m, xv_m, last_m, busy_m, rdy_m, x_l, xv_l, last_l, busy_l, rdy_l});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0] exp;
    din_m = 8'b1101_1011; lv_m = 1'b1;
    push_word(8'b1101_1011, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (rdy_m !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready got=%b exp=1", rdy_m);
    end
    @(posedge clk); #1 lv_m = 1'b0; din_m = 8'h00;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m} !== exp) begin
        n_err++;
        $display("FAIL single[%0d] got=%b exp=%b", i, {x_m, xv_m, last_m, busy_m}, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    din_m = 8'hD6; lv_m = 1'b1;
    push_word(8'hD6, 1'b1);
    push_word(8'hB5, 1'b1);
    @(posedge clk); #1 din_m = 8'hB5;
    for (int i = 0; i < 2 * W + 1; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m} !== exp) begin
        n_err++;
        $display("FAIL b2b[%0d] got=%b exp=%b", i, {x_m, xv_m, last_m, busy_m}, exp);
      end
      n_cmp++;
      if (rdy_m !== (i == W - 1 || i >= 2 * W - 1)) begin
        n_err++;
        $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, rdy_m, (i == W - 1 || i >= 2 * W - 1));
      end
      @(posedge clk); #1;
      if (i == W - 1) lv_m = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp;
    din_m = 8'h3C; lv_m = 1'b1;
    push_word(8'h3C, 1'b1);
    @(posedge clk); #1 din_m = 8'hFF;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m} !== exp) begin
        n_err++;
        $display("FAIL bp[%0d] got=%b exp=%b", i, {x_m, xv_m, last_m, busy_m}, exp);
      end
      n_cmp++;
      if (rdy_m !== (i >= W - 1)) begin
        n_err++;
        $display("FAIL bp_ready[%0d] got=%b exp=%b", i, rdy_m, (i >= W - 1));
      end
      @(posedge clk); #1;
      if (i == W - 2) lv_m = 1'b0;
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp;
    din_l = 8'b0000_0011; lv_l = 1'b1;
    push_word(8'b0000_0011, 1'b0);
    @(posedge clk); #1 lv_l = 1'b0; din_l = 8'hFF;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_l, xv_l, last_l, busy_l} !== exp) begin
        n_err++;
        $display("FAIL lsb[%0d] got=%b exp=%b", i, {x_l, xv_l, last_l, busy_l}, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp;
    din_m = 8'hFF; lv_m = 1'b1;
    push_word(8'hFF, 1'b1);
    @(posedge clk); #1 lv_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m} !== exp) begin
        n_err++;
        $display("FAIL mid_pre[%0d] got=%b exp=%b", i, {x_m, xv_m, last_m, busy_m}, exp);
      end
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_abort got=%b exp=00000", {x_m, xv_m, last_m, busy_m, rdy_m});
    end
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    din_m = 8'h81; lv_m = 1'b1;
    push_word(8'h81, 1'b1);
    @(posedge clk); #1 lv_m = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      exp = next_exp();
      n_cmp++;
      if ({x_m, xv_m, last_m, busy_m} !== exp) begin
        n_err++;
        $display("FAIL mid_post[%0d] got=%b exp=%b", i, {x_m, xv_m, last_m, busy_m}, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_bit_source.md
Name: piso_bit_source

Overview:
- Parallel-in, serial-out stimulus/feed stage that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x, the detector's serial input.
- Gapless back-to-back words are supported, so the detector sees a continuous bit stream.
- Framing signals x_valid and last are provided for the detector-side bench and a downstream match counter.

Parameters:
WIDTH, 8, bits per loaded word (legal range 2..32).
MSB_FIRST, 1, 1 = shift din[WIDTH-1] first; 0 = din[0] first.
IDLE_BIT, 0, level driven on x whenever no word is being shifted.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset, asynchronous, active-high.
din  input  WIDTH  parallel word to serialize.
load_valid  input  1  din is valid this cycle.
load_ready  output  1  block can accept a word this cycle.
x  output  1  serial data bit (registered).
x_valid  output  1  x carries a data bit this cycle (registered).
last  output  1  x carries the final bit of the current word (registered).
busy  output  1  word in progress (state == SHIFT).

Behaviour:
- Reset (async assert, synchronous release on next clk edge):
  - state = IDLE, shift register = 0, bit counter = 0.
  - Outputs: x = IDLE_BIT, x_valid = 0, last = 0, busy = 0.
  - load_ready = 1 after reset; it is 0 while rst is high.
- Handshake: a load occurs on a clk edge where load_valid && load_ready.
  - din is captured on that edge.
  - No load occurs while load_ready = 0. din is ignored and no error is flagged; the producer must hold the word.
- Latency: the first bit of a loaded word appears on x in the cycle immediately after the load edge, together with x_valid = 1. Each bit is held for exactly one clock.
- Bit order: the first bit is din[WIDTH-1] if MSB_FIRST, else din[0]. Following bits proceed downward (or upward) in order.
- FSM states and transitions:
  - IDLE -> SHIFT on load.
  - SHIFT -> SHIFT while the counter is below WIDTH-1.
  - SHIFT -> SHIFT (reload) when the counter equals WIDTH-1 and a load occurs in that cycle.
  - SHIFT -> IDLE when the counter equals WIDTH-1 and no load occurs.
- Counter: 0..WIDTH-1 and equal to the index of the bit currently on x. It is $clog2(WIDTH) bits wide and never wraps past WIDTH-1. It is reset to 0 on every load.
- load_ready = (state == IDLE) || (state == SHIFT && counter == WIDTH-1), and rst is low. It is combinational from state.
- Back-to-back: a load accepted during the last-bit cycle makes bit 0 of the new word follow with no idle cycle. x_valid stays 1 continuously.
- last = 1 exactly while bit WIDTH-1 of a word is on x. It is never 1 when x_valid = 0.
- Returning to IDLE: in the cycle after the last bit without a reload, x = IDLE_BIT and x_valid = 0.
- Changes to din after the load edge have no effect on the word being shifted.
- rst asserted mid-word: the current word is aborted immediately (asynchronously) with no partial completion. Outputs take their reset values.

Decomposition:
- Shared package piso_pkg holds:
  - the state typedef: enum {IDLE, SHIFT}, 1-bit encoding;
  - the localparam CNT_W = $clog2(WIDTH) helper function.
- One sub-module is natural: piso_shift_reg. It holds the WIDTH-bit loadable shift register with a MSB_FIRST-selected output tap and a load/shift enable.
- The FSM, counter and handshake stay in piso_bit_source.

Test Plan:
1. Reset and idle: assert rst for 2 cycles, then release with load_valid = 0 for 5 cycles -> x = 0, x_valid = 0, last = 0, busy = 0, load_ready = 1 throughout.
2. Single word (WIDTH = 8, MSB_FIRST = 1): load din = 8'b11011011 -> x = 1,1,0,1,1,0,1,1 on the 8 cycles after the load edge. last is high only on the 8th cycle; x returns to 0 with x_valid = 0 on the 9th.
3. Back-to-back: load 8'hD6, then hold load_valid with 8'hB5 -> the second load is accepted on the last-bit cycle. The 16 contiguous bits are 1101_0110_1011_0101 with x_valid never dropping and last high on cycles 8 and 16.
4. Backpressure: present din = 8'hFF during bits 0..6 of an active word -> load_ready = 0 and the word is not captured until the cycle where counter = 7. The output stream is unaffected.
5. LSB-first (MSB_FIRST = 0): load 8'b0000_0011 -> x = 1,1,0,0,0,0,0,0.
6. Reset mid-word: load 8'hFF and assert rst asynchronously between edges after 3 bits -> x drops to IDLE_BIT and x_valid/busy drop to 0 without waiting for a clock. After release, a new load 8'h81 produces 1,0,0,0,0,0,0,1 from bit 0.
